// File: rtl/adder_mc_pkg.sv
// -----------------------------------------------------------------------------
// adder_mc_pkg
// Shared types for the multi-channel accumulator block:
//   op_t     - command opcode (INC / DEC / CLR / LOAD)
//   state_t  - command-port readiness FSM states
//   ch_width - derived channel-index width (minimum 1 bit)
// -----------------------------------------------------------------------------
package adder_mc_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_CLR  = 2'd2,
    OP_LOAD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // A single-channel build still needs a 1-bit channel field on the port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_mc_if.sv
// -----------------------------------------------------------------------------
// adder_mc_if
// Valid/ready command bus for adder_mc.
//   cmd_valid  command present (master -> slave)
//   cmd_ready  slave can accept a command this cycle (slave -> master)
//   cmd_ch     target channel
//   cmd_op     opcode (op_t)
//   cmd_step   INC/DEC amount, zero-extended inside the block
//   cmd_data   LOAD value
// Modports: master (command source), slave (adder_mc).
// -----------------------------------------------------------------------------
interface adder_mc_if
  import adder_mc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int STEP_W = 4
) ();

  localparam int CH_W = ch_width(NCH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  op_t               cmd_op;
  logic [STEP_W-1:0] cmd_step;
  logic [WIDTH-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_ch, cmd_op, cmd_step, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_op, cmd_step, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/adder_mc_alu.sv
// -----------------------------------------------------------------------------
// adder_mc_alu
// Purely combinational next-value computation for one accumulator command.
//   acc        current accumulator value
//   op         opcode
//   step       INC/DEC amount (zero-extended to WIDTH)
//   data       LOAD value
//   nxt        resulting accumulator value
//   set_ovf    INC produced a carry out of WIDTH bits
//   set_udf    DEC step exceeded the current value
//   clr_flags  command clears the channel's sticky flags (CLR)
// SATURATE=0 wraps modulo 2^WIDTH, SATURATE=1 clamps to 0 / all-ones.
// -----------------------------------------------------------------------------
module adder_mc_alu
  import adder_mc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0]  acc,
  input  op_t               op,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  nxt,
  output logic              set_ovf,
  output logic              set_udf,
  output logic              clr_flags
);

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Widen the step and form both candidate results once.
  always_comb begin
    step_ext               = {WIDTH{1'b0}};
    step_ext[STEP_W-1:0]   = step;
    sum                    = {1'b0, acc} + {1'b0, step_ext};
    diff                   = acc - step_ext;
    borrow                 = (step_ext > acc);
  end

  // Select result and flag effects for the opcode.
  always_comb begin
    nxt       = acc;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    clr_flags = 1'b0;
    case (op)
      OP_INC: begin
        set_ovf = sum[WIDTH];
        if (sum[WIDTH] && (SATURATE != 0)) begin
          nxt = {WIDTH{1'b1}};
        end else begin
          nxt = sum[WIDTH-1:0];
        end
      end
      OP_DEC: begin
        set_udf = borrow;
        if (borrow && (SATURATE != 0)) begin
          nxt = {WIDTH{1'b0}};
        end else begin
          nxt = diff;
        end
      end
      OP_CLR: begin
        nxt       = {WIDTH{1'b0}};
        clr_flags = 1'b1;
      end
      OP_LOAD: begin
        nxt = data;
      end
      default: begin
        nxt = acc;
      end
    endcase
  end

endmodule

// File: rtl/adder_mc.sv
// -----------------------------------------------------------------------------
// adder_mc
// NCH independent WIDTH-bit accumulators driven through a valid/ready
// command port, with sticky per-channel overflow/underflow flags.
//   aclk      clock, rising edge
//   srst      synchronous active-high reset
//   cmd       adder_mc_if.slave command bus
//   flag_clr  per-channel sticky-flag clear (a same-edge flag set wins)
//   out       flattened accumulators, channel i at [i*WIDTH +: WIDTH]
//   ovf/udf   sticky overflow / underflow per channel
//   upd       one-cycle pulse for the channel written at the previous edge
// Optional macro ADDER_MC_THRESH_EN adds:
//   thresh    per-channel threshold (flattened like out)
//   thr_hit   registered (out_i >= thresh_i), one cycle behind out
//   and holds cmd_ready low for one cycle after any thr_hit rising edge.
// Commands addressing a channel >= NCH are accepted and discarded.
// -----------------------------------------------------------------------------
module adder_mc
  import adder_mc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic                 aclk,
  input  logic                 srst,
  adder_mc_if.slave            cmd,
  input  logic [NCH-1:0]       flag_clr,
`ifdef ADDER_MC_THRESH_EN
  input  logic [NCH*WIDTH-1:0] thresh,
  output logic [NCH-1:0]       thr_hit,
`endif
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       udf,
  output logic [NCH-1:0]       upd
);

  localparam int CH_W = ch_width(NCH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             ch_ok;
  logic             hold;
  logic [WIDTH-1:0] acc [NCH];
  logic [WIDTH-1:0] acc_sel;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   ovf_nxt;
  logic [NCH-1:0]   udf_nxt;
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_ovf;
  logic             alu_udf;
  logic             alu_clr;

  // ---------------------------------------------------------------------------
  // Readiness FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one warm-up cycle between reset release and RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST: begin
        if (srst) begin
          state_nxt = ST_RST;
        end else begin
          state_nxt = ST_WARM;
        end
      end
      ST_WARM: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (srst) begin
          state_nxt = ST_RST;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  // Output logic: srst gates ready immediately so nothing is accepted on the
  // reset edge, even when reset arrives while in RUN.
  always_comb begin
    cmd.cmd_ready = 1'b0;
    case (state)
      ST_RUN: begin
        cmd.cmd_ready = !srst && !hold;
      end
      default: begin
        cmd.cmd_ready = 1'b0;
      end
    endcase
  end

  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // ---------------------------------------------------------------------------
  // Channel decode
  // ---------------------------------------------------------------------------

  // When NCH fills the index space every code is a real channel.
  if (NCH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (cmd.cmd_ch < CH_W'(NCH));
  end

  // One-hot write enable and AND-OR mux of the addressed accumulator.
  always_comb begin
    acc_sel = {WIDTH{1'b0}};
    hit     = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = accept && ch_ok && (cmd.cmd_ch == CH_W'(i));
      acc_sel = acc_sel | (acc[i] & {WIDTH{ch_ok && (cmd.cmd_ch == CH_W'(i))}});
    end
  end

  adder_mc_alu #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .SATURATE (SATURATE)
  ) u_alu (
    .acc       (acc_sel),
    .op        (cmd.cmd_op),
    .step      (cmd.cmd_step),
    .data      (cmd.cmd_data),
    .nxt       (alu_nxt),
    .set_ovf   (alu_ovf),
    .set_udf   (alu_udf),
    .clr_flags (alu_clr)
  );

  // ---------------------------------------------------------------------------
  // Accumulators and sticky flags
  // ---------------------------------------------------------------------------

  // Flag update: flag_clr first, then the command's own effect, so a
  // same-edge set overrides the external clear and CLR clears everything.
  always_comb begin
    ovf_nxt = {NCH{1'b0}};
    udf_nxt = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (hit[i]) begin
        ovf_nxt[i] = !alu_clr && ((ovf[i] && !flag_clr[i]) || alu_ovf);
        udf_nxt[i] = !alu_clr && ((udf[i] && !flag_clr[i]) || alu_udf);
      end else begin
        ovf_nxt[i] = ovf[i] && !flag_clr[i];
        udf_nxt[i] = udf[i] && !flag_clr[i];
      end
    end
  end

  // Accumulator array, flags and update pulse. Because the written value is
  // registered at the accept edge, a back-to-back command reads it directly.
  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= {WIDTH{1'b0}};
      end
      ovf <= {NCH{1'b0}};
      udf <= {NCH{1'b0}};
      upd <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          acc[i] <= alu_nxt;
        end else begin
          acc[i] <= acc[i];
        end
      end
      ovf <= ovf_nxt;
      udf <= udf_nxt;
      upd <= hit;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = acc[g];
  end

  // ---------------------------------------------------------------------------
  // Optional threshold detection
  // ---------------------------------------------------------------------------
`ifdef ADDER_MC_THRESH_EN
  logic [NCH-1:0] thr_now;

  // Unregistered compare of the current accumulators against thresholds.
  always_comb begin
    thr_now = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      thr_now[i] = (acc[i] >= thresh[i*WIDTH +: WIDTH]);
    end
  end

  // Register thr_hit and raise a one-cycle hold on any newly asserted bit.
  always_ff @(posedge aclk) begin
    if (srst) begin
      thr_hit <= {NCH{1'b0}};
      hold    <= 1'b0;
    end else begin
      thr_hit <= thr_now;
      hold    <= |(thr_now & ~thr_hit);
    end
  end
`else
  assign hold = 1'b0;
`endif

endmodule

// File: doc/adder_mc.md
Name: adder_mc

Overview:
- Multi-channel, parametrised successor to the single up-counter `Adder`.
- Holds NCH independent WIDTH-bit accumulators, updated through a valid/ready command port.
- Commands: increment by step, decrement by step, clear, load.
- Each channel has sticky overflow/underflow flags and a selectable wrap or saturate mode; used for event and statistics counting in SVUT-tested designs.

Parameters:
- WIDTH, 8, bits per accumulator (>=2).
- NCH, 4, number of channels (>=1).
- STEP_W, 4, width of step/increment operand (<=WIDTH).
- SATURATE, 0, 0 = modular wrap, 1 = clamp at 0 / 2^WIDTH-1.
- CH_W, $clog2(NCH) min 1, derived channel-index width (localparam).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- srst  in  1  reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept command.
- cmd_ch  in  CH_W  target channel.
- cmd_op  in  2  opcode: 0 INC, 1 DEC, 2 CLR, 3 LOAD.
- cmd_step  in  STEP_W  INC/DEC amount, zero-extended.
- cmd_data  in  WIDTH  LOAD value.
- flag_clr  in  NCH  per-channel sticky-flag clear.
- out  out  NCH*WIDTH  flattened accumulators; channel i at [i*WIDTH +: WIDTH].
- ovf  out  NCH  sticky overflow per channel.
- udf  out  NCH  sticky underflow per channel.
- upd  out  NCH  one-cycle pulse, channel written last cycle.

Interface timing: one clock; reset is synchronous and active-high.

Behaviour:
- **Reset** (srst high at a rising edge):
  - out = 0, ovf = 0, udf = 0, upd = 0.
  - cmd_ready = 0 while srst is high and for 1 cycle after srst falls, then 1.
  - Reset mid-operation discards any in-flight command.
- **Handshake:**
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready stays 1 outside reset; there is no backpressure in the base configuration.
  - Commands with cmd_ch >= NCH are accepted and ignored: no state change, no upd.
- **Latency:**
  - An accepted command at edge N is visible on out and upd at edge N+1.
  - Back-to-back commands to the same channel must chain correctly, i.e. use the forwarded latest value; there are no bubbles.
- **INC:**
  - sum = acc + step, computed at WIDTH+1 bits.
  - If the carry is set: ovf[ch] <= 1; result = sum[WIDTH-1:0] when SATURATE=0, else all-ones.
- **DEC:**
  - If step > acc: udf[ch] <= 1; result = acc - step modulo 2^WIDTH when SATURATE=0, else 0.
- **Zero step:** INC/DEC with step 0 leave the value unchanged but still pulse upd.
- **CLR:** acc <= 0; ovf[ch] and udf[ch] <= 0.
- **LOAD:** acc <= cmd_data; flags unchanged.
- **flag_clr[i]:** clears ovf[i]/udf[i] at the next edge.
  - If the same-edge command sets the flag, the set wins.
  - Flags never clear spontaneously.
- **upd:** upd[ch] = 1 for exactly one cycle after each accepted, valid-channel command; otherwise 0.
- **FSM (ready control):**
  - RST: cmd_ready = 0; leave when srst = 0 → WARM.
  - WARM: 1 cycle, cmd_ready = 0 → RUN.
  - RUN: cmd_ready = 1; srst → RST.

Optional Feature:
- Macro: ADDER_MC_THRESH_EN.
- When defined, adds:
  - Input thresh (NCH*WIDTH): per-channel threshold.
  - Output thr_hit (NCH): thr_hit[i] is registered, equal to (out_i >= thresh_i), updated the cycle after out changes (1-cycle lag behind out).
  - cmd_ready drops for 1 cycle after any edge that newly asserts thr_hit; commands are held off during that cycle.
- When undefined: no thresh or thr_hit ports, and cmd_ready is never deasserted in RUN.

Decomposition:
- Package adder_mc_pkg holds:
  - typedef enum logic[1:0] op_t {OP_INC, OP_DEC, OP_CLR, OP_LOAD}.
  - The ready-FSM state enum {ST_RST, ST_WARM, ST_RUN}.
- One natural sub-module, adder_mc_alu: combinational next-value, ovf and udf computation for one operation, parametrised on WIDTH, STEP_W and SATURATE.
- The top level holds the register array, handshake FSM and flag logic.

Test Plan:
- Reset: srst high for 3 cycles, then low → out = 0, flags = 0; cmd_ready 0 during reset, 0 one cycle after, then 1.
- Wrap (SATURATE=0, WIDTH=8): LOAD ch1 = 250, then INC step 10 → out ch1 = 4, ovf[1] = 1, other channels 0.
- Saturate (SATURATE=1): LOAD ch0 = 3, DEC step 5 → ch0 = 0, udf[0] = 1; INC step 15 ×20 → ch0 = 255, ovf[0] = 1.
- Back-to-back: ch2 INC 1, INC 2, INC 3 on consecutive edges → ch2 = 1, 3, 6; upd[2] high 3 cycles.
- Flags: ovf[1] set, pulse flag_clr[1] → cleared; flag_clr[1] on the same edge as an overflowing INC → ovf[1] stays 1; CLR ch1 → value and flags 0.
- Invalid channel (NCH=3, cmd_ch=3): INC → out, flags and upd unchanged; with ADDER_MC_THRESH_EN, thresh ch0 = 5 and 5×INC 1 → thr_hit[0] = 1 one cycle after out = 5, cmd_ready low 1 cycle.
